univ_shift_reg_n: RTL and testbench

Parametrised N-bit universal shift register: parallel load, logical/arithmetic shifts and rotates in both directions, plus a counted burst mode that applies a programmed number of single-bit steps under an FSM with busy/done handshake. It is the general-purpose successor to the team's fixed-direction left shift register. It sits in serial-link and datapath blocks wherever words are loaded, serialised, deserialised or realigned.

---
 rtl/shift_pkg.sv | 26 ++
 rtl/shift_step.sv | 27 ++
 rtl/univ_shift_reg_n.sv | 100 ++++++++++
 tb/tb_univ_shift_reg_n.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared encodings for the universal shift register: mode codes, FSM states
// and the decode of which modes may run as a counted burst.
package shift_pkg;

  localparam int unsigned MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_HOLD = 3'b000;
  localparam logic [MODE_W-1:0] MODE_LOAD = 3'b001;
  localparam logic [MODE_W-1:0] MODE_SHL  = 3'b010;
  localparam logic [MODE_W-1:0] MODE_SHR  = 3'b011;
  localparam logic [MODE_W-1:0] MODE_SAR  = 3'b100;
  localparam logic [MODE_W-1:0] MODE_ROL  = 3'b101;
  localparam logic [MODE_W-1:0] MODE_ROR  = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Only true shift/rotate modes can be repeated as a burst.
  function automatic logic is_burst_mode(input logic [MODE_W-1:0] m);
    return (m >= MODE_SHL) && (m <= MODE_ROR);
  endfunction

endpackage

// File: rtl/shift_step.sv
// One-step shift/rotate datapath; hold, load and reserved codes pass q through
// (load is muxed in by the parent, which owns d).
module shift_step
  import shift_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0]      i_q,
  input  logic [MODE_W-1:0] i_mode,
  input  logic              i_sil,
  input  logic              i_sir,
  output logic [N-1:0]      o_q_c
);

  always_comb begin
    o_q_c = i_q;
    case (i_mode)
      MODE_SHL: o_q_c = {i_q[N-2:0], i_sil};
      MODE_SHR: o_q_c = {i_sir, i_q[N-1:1]};
      MODE_SAR: o_q_c = {i_q[N-1], i_q[N-1:1]};
      MODE_ROL: o_q_c = {i_q[N-2:0], i_q[N-1]};
      MODE_ROR: o_q_c = {i_q[0], i_q[N-1:1]};
      default:  o_q_c = i_q;
    endcase
  end

endmodule

// File: rtl/univ_shift_reg_n.sv
// N-bit universal shift register with single-step operation and a counted
// burst mode (IDLE -> SHIFT -> DONE) signalled through busy/done.
module univ_shift_reg_n
  import shift_pkg::*;
#(
  parameter  int unsigned N  = 8,
  localparam int unsigned CW = $clog2(N + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [MODE_W-1:0] mode,
  input  logic [N-1:0]      d,
  input  logic              SIL,
  input  logic              SIR,
  input  logic              start,
  input  logic [CW-1:0]     cnt,
  output logic              busy,
  output logic              done,
  output logic              SOL,
  output logic              SOR,
  output logic [N-1:0]      q
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [N-1:0]      r_q;
  logic [N-1:0]      w_q_nxt;
  logic [CW-1:0]     r_cnt;
  logic [CW-1:0]     w_cnt_nxt;
  logic [MODE_W-1:0] r_mode;
  logic [MODE_W-1:0] w_mode_nxt;
  logic [MODE_W-1:0] w_step_mode;
  logic [N-1:0]      w_step_q;

  // During a burst the latched mode drives the datapath; live mode otherwise.
  assign w_step_mode = (r_state == ST_SHIFT) ? r_mode : mode;

  shift_step #(.N(N)) u_step (
    .i_q    (r_q),
    .i_mode (w_step_mode),
    .i_sil  (SIL),
    .i_sir  (SIR),
    .o_q_c  (w_step_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_q     <= '0;
      r_cnt   <= '0;
      r_mode  <= MODE_HOLD;
    end else begin
      r_state <= w_state_nxt;
      r_q     <= w_q_nxt;
      r_cnt   <= w_cnt_nxt;
      r_mode  <= w_mode_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_q_nxt     = r_q;
    w_cnt_nxt   = r_cnt;
    w_mode_nxt  = r_mode;
    case (r_state)
      ST_IDLE: begin
        if (en) begin
          if (start && is_burst_mode(mode)) begin
            w_mode_nxt  = mode;
            w_cnt_nxt   = cnt;
            w_state_nxt = (cnt == '0) ? ST_DONE : ST_SHIFT;
          end else if (mode == MODE_LOAD) begin
            w_q_nxt = d;
          end else begin
            w_q_nxt = w_step_q;
          end
        end
      end
      ST_SHIFT: begin
        if (en) begin
          w_q_nxt   = w_step_q;
          w_cnt_nxt = r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign busy = (r_state == ST_SHIFT);
  assign done = (r_state == ST_DONE);
  assign q    = r_q;
  assign SOL  = r_q[N-1];
  assign SOR  = r_q[0];

endmodule

// File: tb/tb_univ_shift_reg_n.sv
// Directed and randomized bench for univ_shift_reg_n (N=8), checked against
// an arithmetic reference model of the shift rules and burst handshake.
module tb_univ_shift_reg_n;

  localparam int unsigned N  = 8;
  localparam int unsigned CW = $clog2(N + 1);

  logic          clk;
  logic          rst;
  logic          en;
  logic [2:0]    mode;
  logic [N-1:0]  d;
  logic          SIL;
  logic          SIR;
  logic          start;
  logic [CW-1:0] cnt;
  logic          busy;
  logic          done;
  logic          SOL;
  logic          SOR;
  logic [N-1:0]  q;

  int checks;
  int failures;

  univ_shift_reg_n #(.N(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .mode  (mode),
    .d     (d),
    .SIL   (SIL),
    .SIR   (SIR),
    .start (start),
    .cnt   (cnt),
    .busy  (busy),
    .done  (done),
    .SOL   (SOL),
    .SOR   (SOR),
    .q     (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_st(input string tag, input logic [7:0] eq, input bit eb, input bit ed);
    chk({tag, "_q"}, 32'(q), 32'(eq));
    chk({tag, "_busy"}, 32'(busy), 32'(eb));
    chk({tag, "_done"}, 32'(done), 32'(ed));
  endtask

  task automatic load(input logic [7:0] v);
    en = 1'b1; start = 1'b0; mode = 3'b001; d = v;
    tick();
  endtask

  // Reference one-step rules written as integer arithmetic on the word value.
  function automatic logic [7:0] ref_step(input int m, input int v, input int sil, input int sir);
    case (m)
      2: return 8'((v * 2 + sil) % 256);
      3: return 8'(v / 2 + sir * 128);
      4: return 8'(v / 2 + ((v >= 128) ? 128 : 0));
      5: return 8'((v * 2) % 256 + v / 128);
      6: return 8'(v / 2 + (v % 2) * 128);
      default: return 8'(v);
    endcase
  endfunction

  initial begin
    int m_q, m_rem, m_mode, m_phase;
    checks = 0; failures = 0;
    rst = 1'b1; en = 1'b0; mode = 3'b000; d = '0; SIL = 1'b0; SIR = 1'b0;
    start = 1'b0; cnt = '0;
    #12;
    chk_st("reset", 8'h00, 1'b0, 1'b0);
    chk("reset_sol", 32'(SOL), 32'd0);
    chk("reset_sor", 32'(SOR), 32'd0);
    rst = 1'b0;

    load(8'hA5);
    chk("load_q", 32'(q), 32'hA5);
    chk("load_sol", 32'(SOL), 32'd1);
    chk("load_sor", 32'(SOR), 32'd1);

    mode = 3'b010; SIL = 1'b1; tick();
    chk("shl", 32'(q), 32'h4B);
    load(8'hA5);
    mode = 3'b011; SIR = 1'b0; tick();
    chk("shr", 32'(q), 32'h52);
    load(8'h96);
    mode = 3'b100; tick();
    chk("sar", 32'(q), 32'hCB);
    for (int m = 0; m < 8; m++) begin
      en = 1'b0; mode = 3'(m); d = 8'h11; tick();
      chk("en_low_hold", 32'(q), 32'hCB);
    end
    en = 1'b1; mode = 3'b111; tick();
    chk("reserved_hold", 32'(q), 32'hCB);

    // Burst ROL x3; start and load on mode/d during the burst must be ignored.
    load(8'h81);
    start = 1'b1; mode = 3'b101; cnt = CW'(3); tick();
    chk_st("rol_acc", 8'h81, 1'b1, 1'b0);
    mode = 3'b001; d = 8'h00; cnt = CW'(1);
    tick(); chk_st("rol_s1", 8'h03, 1'b1, 1'b0);
    tick(); chk_st("rol_s2", 8'h06, 1'b1, 1'b0);
    tick(); chk_st("rol_s3", 8'h0C, 1'b0, 1'b1);
    tick(); chk_st("rol_done_ign", 8'h0C, 1'b0, 1'b0);
    start = 1'b0;

    // Burst ROR x4 with a two-cycle stall.
    load(8'hF0);
    start = 1'b1; mode = 3'b110; cnt = CW'(4); tick();
    chk_st("ror_acc", 8'hF0, 1'b1, 1'b0);
    start = 1'b0; mode = 3'b000;
    tick(); chk_st("ror_s1", 8'h78, 1'b1, 1'b0);
    en = 1'b0;
    tick(); chk_st("ror_st1", 8'h78, 1'b1, 1'b0);
    tick(); chk_st("ror_st2", 8'h78, 1'b1, 1'b0);
    en = 1'b1;
    tick(); chk_st("ror_s2", 8'h3C, 1'b1, 1'b0);
    tick(); chk_st("ror_s3", 8'h1E, 1'b1, 1'b0);
    tick(); chk_st("ror_s4", 8'h0F, 1'b0, 1'b1);
    tick(); chk_st("ror_after", 8'h0F, 1'b0, 1'b0);

    // cnt = 0 burst.
    load(8'h5A);
    start = 1'b1; mode = 3'b010; cnt = '0; tick();
    start = 1'b0; mode = 3'b000;
    chk_st("cnt0_acc", 8'h5A, 1'b0, 1'b1);
    tick(); chk_st("cnt0_after", 8'h5A, 1'b0, 1'b0);

    // SHL burst longer than N saturates to SIL.
    load(8'hFF);
    start = 1'b1; mode = 3'b010; cnt = CW'(9); SIL = 1'b0; tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    chk_st("shl9", 8'h00, 1'b0, 1'b1);
    tick();

    // start with load mode is a plain load.
    start = 1'b1; mode = 3'b001; d = 8'h3C; cnt = CW'(2); tick();
    start = 1'b0;
    chk_st("start_load", 8'h3C, 1'b0, 1'b0);
    tick(); chk_st("start_load2", 8'h3C, 1'b0, 1'b0);

    // Asynchronous reset mid-burst, away from any clock edge.
    start = 1'b1; mode = 3'b101; cnt = CW'(5); tick();
    start = 1'b0; tick();
    chk_st("pre_rst", 8'h78, 1'b1, 1'b0);
    #2 rst = 1'b1; #1;
    chk_st("async_rst", 8'h00, 1'b0, 1'b0);
    #1 rst = 1'b0;
    tick();
    chk_st("post_rst", 8'h78 & 8'h00, 1'b0, 1'b0);

    // Randomized cycles against the reference model.
    m_q = 0; m_rem = 0; m_mode = 0; m_phase = 0;
    for (int it = 0; it < 400; it++) begin
      int r_en, r_start, r_mode, r_d, r_sil, r_sir, r_cnt;
      r_en    = ($urandom_range(0, 9) != 0) ? 1 : 0;
      r_start = ($urandom_range(0, 4) == 0) ? 1 : 0;
      r_mode  = $urandom_range(0, 7);
      r_d     = $urandom_range(0, 255);
      r_sil   = $urandom_range(0, 1);
      r_sir   = $urandom_range(0, 1);
      r_cnt   = $urandom_range(0, 10);
      en = 1'(r_en); start = 1'(r_start); mode = 3'(r_mode); d = 8'(r_d);
      SIL = 1'(r_sil); SIR = 1'(r_sir); cnt = CW'(r_cnt);
      case (m_phase)
        0: if (r_en == 1) begin
          if (r_start == 1 && r_mode >= 2 && r_mode <= 6) begin
            m_mode = r_mode; m_rem = r_cnt;
            m_phase = (r_cnt == 0) ? 2 : 1;
          end else if (r_mode == 1) begin
            m_q = r_d;
          end else begin
            m_q = int'(ref_step(r_mode, m_q, r_sil, r_sir));
          end
        end
        1: if (r_en == 1) begin
          m_q = int'(ref_step(m_mode, m_q, r_sil, r_sir));
          m_rem--;
          if (m_rem == 0) m_phase = 2;
        end
        default: m_phase = 0;
      endcase
      tick();
      chk_st("rand", 8'(m_q), (m_phase == 1), (m_phase == 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
